// File: rtl/sll_multicycle.sv
// Iterative 32-bit logical left shifter. One binary-weighted stage (16, 8, 4, 2, 1)
// is applied per cycle, so a single shift stage is reused across five cycles.
module sll_multicycle (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic [31:0] data_operand,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  amt_q, amt_d;

  logic        accept;
  logic [4:0]  shift_dist;
  logic [2:0]  amt_idx;

  // Starts are taken in IDLE and in DONE (back-to-back); ignored while shifting.
  assign accept     = ctrl_shift && (state_q != StShift);
  // Stage k shifts by 16 >> k and is gated by amt bit 4-k (MSB first).
  assign shift_dist = 5'd16 >> k_q;
  assign amt_idx    = 3'd4 - k_q;

  // Next-state logic: accept, per-stage conditional shift, DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    acc_d   = acc_q;
    amt_d   = amt_q;
    case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          acc_d   = data_operand;
          amt_d   = shamt;
          k_d     = 3'd0;
          state_d = StShift;
        end else begin
          state_d = StIdle;
        end
      end
      StShift: begin
        if (amt_q[amt_idx]) begin
          acc_d = acc_q << shift_dist;
        end
        if (k_q == 3'd4) begin
          state_d = StDone;
        end else begin
          k_d = k_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; asynchronous reset clears everything, aborting any operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= 3'd0;
      acc_q   <= 32'd0;
      amt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      amt_q   <= amt_d;
    end
  end

  assign data_result    = acc_q;
  assign data_resultRDY = (state_q == StDone);
  assign busy           = (state_q == StShift);

endmodule

// File: tb/tb_sll_multicycle.sv
// Self-checking bench for sll_multicycle: table vectors, random operations against
// a plain-arithmetic model, and hand-written multi-cycle corner sequences.
module tb_sll_multicycle;

  logic        clock;
  logic        reset;
  logic        ctrl_shift;
  logic [31:0] data_operand;
  logic [4:0]  shamt;
  logic [31:0] data_result;
  logic        data_resultRDY;
  logic        busy;

  int tests;
  int fails;

  sll_multicycle dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_shift     (ctrl_shift),
    .data_operand   (data_operand),
    .shamt          (shamt),
    .data_result    (data_result),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] op;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] ref_sll(input logic [31:0] op, input int sh);
    logic [63:0] wide;
    wide = {32'd0, op} * (64'd1 << sh);
    return wide[31:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Full operation from IDLE with latency, busy, pulse width and hold checks.
  task automatic run_op(input logic [31:0] op, input logic [4:0] sh, input logic [31:0] exp,
                        input string name);
    ctrl_shift   = 1'b1;
    data_operand = op;
    shamt        = sh;
    tick();  // E0
    ctrl_shift   = 1'b0;
    data_operand = $urandom;
    shamt        = 5'($urandom_range(0, 31));
    chk({name, " busy_e0"}, 32'(busy), 32'd1);
    chk({name, " rdy_e0"}, 32'(data_resultRDY), 32'd0);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk({name, " busy_mid"}, 32'(busy), 32'd1);
      chk({name, " rdy_mid"}, 32'(data_resultRDY), 32'd0);
    end
    tick();  // E5
    chk({name, " rdy_e5"}, 32'(data_resultRDY), 32'd1);
    chk({name, " busy_e5"}, 32'(busy), 32'd0);
    chk({name, " result"}, data_result, exp);
    tick();  // E6
    chk({name, " rdy_e6"}, 32'(data_resultRDY), 32'd0);
    chk({name, " hold"}, data_result, exp);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0] rop;
    logic [4:0]  rsh;
    int          pulses;

    tests = 0;
    fails = 0;
    vecs[0] = '{32'h0000_0001, 5'd16, 32'h0001_0000};
    vecs[1] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[2] = '{32'h1234_5678, 5'd4,  32'h2345_6780};
    vecs[3] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4] = '{32'hA5A5_A5A5, 5'd21, 32'hB4A0_0000};
    vecs[5] = '{32'h8000_0001, 5'd1,  32'h0000_0002};

    reset        = 1'b1;
    ctrl_shift   = 1'b0;
    data_operand = 32'd0;
    shamt        = 5'd0;
    tick();
    tick();
    chk("reset result", data_result, 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].sh, vecs[i].exp, $sformatf("vec%0d", i));
      tick();
    end

    for (int i = 0; i < 30; i++) begin
      rop = $urandom;
      rsh = 5'($urandom_range(0, 31));
      run_op(rop, rsh, ref_sll(rop, int'(rsh)), $sformatf("rand%0d", i));
    end

    // Start while busy: requests on E2..E4 must be ignored.
    ctrl_shift   = 1'b1;
    data_operand = 32'h1;
    shamt        = 5'd1;
    tick();  // E0
    ctrl_shift   = 1'b0;
    tick();  // E1
    ctrl_shift   = 1'b1;
    shamt        = 5'd31;
    tick();  // E2
    tick();  // E3
    tick();  // E4
    ctrl_shift   = 1'b0;
    chk("busy_ign busy_e4", 32'(busy), 32'd1);
    tick();  // E5
    chk("busy_ign rdy", 32'(data_resultRDY), 32'd1);
    chk("busy_ign result", data_result, 32'h2);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (data_resultRDY || busy) pulses++;
    end
    chk("busy_ign no_second_op", 32'(pulses), 32'd0);

    // Reset mid-operation, between E2 and E3.
    ctrl_shift   = 1'b1;
    data_operand = 32'h1;
    shamt        = 5'd8;
    tick();  // E0
    ctrl_shift   = 1'b0;
    tick();  // E1
    tick();  // E2
    reset = 1'b1;
    #1;
    chk("midrst result", data_result, 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst rdy", 32'(data_resultRDY), 32'd0);
    pulses = 0;
    tick();
    if (data_resultRDY) pulses++;
    tick();
    if (data_resultRDY) pulses++;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (data_resultRDY) pulses++;
    end
    chk("midrst no_rdy", 32'(pulses), 32'd0);
    run_op(32'h3, 5'd2, 32'hC, "after_rst");

    // Back-to-back: second start during the DONE cycle.
    ctrl_shift   = 1'b1;
    data_operand = 32'h1;
    shamt        = 5'd1;
    tick();  // E0
    ctrl_shift   = 1'b0;
    for (int i = 1; i <= 5; i++) tick();  // E5
    chk("b2b rdy1", 32'(data_resultRDY), 32'd1);
    chk("b2b result1", data_result, 32'h2);
    ctrl_shift   = 1'b1;
    data_operand = 32'h1;
    shamt        = 5'd3;
    tick();  // E6
    ctrl_shift   = 1'b0;
    chk("b2b rdy_e6", 32'(data_resultRDY), 32'd0);
    chk("b2b busy_e6", 32'(busy), 32'd1);
    chk("b2b operand_e6", data_result, 32'h1);
    for (int i = 7; i <= 10; i++) begin
      tick();
      chk("b2b busy_mid", 32'(busy), 32'd1);
    end
    tick();  // E11
    chk("b2b rdy2", 32'(data_resultRDY), 32'd1);
    chk("b2b result2", data_result, 32'h8);
    tick();
    chk("b2b rdy2_end", 32'(data_resultRDY), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
